core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback around the integer instruction decoder, ALU, register file and data bus. It owns the PC register and next-PC selection. It drives the instruction and data memory req/ack handshakes and the register-file write strobe, and traps on illegal instructions or bus timeout.

---
 rtl/core_pkg.sv | 23 ++
 rtl/core_next_pc.sv | 30 +++
 rtl/core_sequencer.sv | 167 ++++++++++++++++
 tb/tb_core_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle core: FSM state encoding,
// trap cause codes and the architectural reset vector.
package core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_IMEM_TO = 2'd2,
        CAUSE_DMEM_TO = 2'd3
    } cause_t;

    localparam logic [31:0] RV_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/core_next_pc.sv
// Combinational next-PC selection for RV32I control transfers.
// Shared with the pipelined core, so it holds no state of its own.
module core_next_pc (
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_alu_result,
    input  logic        i_jump,
    input  logic        i_jalr,
    input  logic        i_branch,
    input  logic        i_branch_taken,
    output logic [31:0] o_next_pc,
    output logic [31:0] o_pc_plus4
);

    logic [31:0] w_pc_rel;

    assign o_pc_plus4 = i_pc + 32'd4;
    assign w_pc_rel   = i_pc + i_imm;

    always_comb begin
        o_next_pc = o_pc_plus4;
        if (i_jalr)
            o_next_pc = i_alu_result & ~32'd1;
        else if (i_jump)
            o_next_pc = w_pc_rel;
        else if (i_branch && i_branch_taken)
            o_next_pc = w_pc_rel;
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the RV32I core.
// state   | meaning
// FETCH   | imem_req high until imem_ack (ir_load on ack) or timeout
// DECODE  | check instr_legal
// EXECUTE | alu_en, capture branch_taken/alu_result
// MEM     | dmem_req high until dmem_ack or timeout
// WB      | reg_we, PC update
// TRAP    | terminal until rst
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RV_RESET_VECTOR,
    parameter int          BUS_TIMEOUT = 16,
    parameter int          TO_W        = $clog2(BUS_TIMEOUT) + 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_load,
    input  logic        instr_legal,
    input  logic        jump,
    input  logic        jalr,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic        data_r,
    input  logic        data_w,
    input  logic        reg_w,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        reg_we,
    output logic        alu_en,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUS_TIMEOUT - 1);

    state_t          r_state;
    cause_t          r_cause;
    logic            r_trap;
    logic [31:0]     r_pc;
    logic [31:0]     r_alu_result;
    logic            r_br_taken;
    logic [TO_W-1:0] r_to_cnt;

    logic            w_in_exec;
    logic            w_taken;
    logic            w_to_expire;
    logic [31:0]     w_alu_sel;
    logic [31:0]     w_next_pc;
    logic [31:0]     w_pc_plus4;

    // EXECUTE retires straight to FETCH using live ALU values; later states use the captured copies.
    assign w_in_exec   = (r_state == ST_EXECUTE);
    assign w_taken     = w_in_exec ? branch_taken : r_br_taken;
    assign w_alu_sel   = w_in_exec ? alu_result   : r_alu_result;
    assign w_to_expire = (r_to_cnt == TO_LAST);

    core_next_pc u_next_pc (
        .i_pc           (r_pc),
        .i_imm          (imm),
        .i_alu_result   (w_alu_sel),
        .i_jump         (jump),
        .i_jalr         (jalr),
        .i_branch       (branch),
        .i_branch_taken (w_taken),
        .o_next_pc      (w_next_pc),
        .o_pc_plus4     (w_pc_plus4)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_trap       <= 1'b0;
            r_cause      <= CAUSE_NONE;
            r_to_cnt     <= '0;
            r_alu_result <= '0;
            r_br_taken   <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_state <= ST_DECODE;
                    end else if (w_to_expire) begin
                        r_state <= ST_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= CAUSE_IMEM_TO;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (!instr_legal) begin
                        r_state <= ST_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= CAUSE_ILLEGAL;
                    end else begin
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    r_alu_result <= alu_result;
                    r_br_taken   <= branch_taken;
                    r_to_cnt     <= '0;
                    if (data_r || data_w) begin
                        r_state <= ST_MEM;
                    end else if (reg_w) begin
                        r_state <= ST_WB;
                    end else begin
                        r_state <= ST_FETCH;
                        r_pc    <= w_next_pc;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        if (data_r) begin
                            r_state <= ST_WB;
                        end else begin
                            r_state  <= ST_FETCH;
                            r_pc     <= w_next_pc;
                            r_to_cnt <= '0;
                        end
                    end else if (w_to_expire) begin
                        r_state <= ST_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= CAUSE_DMEM_TO;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_WB: begin
                    r_state  <= ST_FETCH;
                    r_pc     <= w_next_pc;
                    r_to_cnt <= '0;
                end
                ST_TRAP: begin
                    r_state <= ST_TRAP;
                end
                default: begin
                    r_state <= ST_TRAP;
                end
            endcase
        end
    end

    // Strobes decode the state register and are forced low while rst is asserted.
    assign imem_req   = !rst && (r_state == ST_FETCH);
    assign ir_load    = imem_req && imem_ack;
    assign dmem_req   = !rst && (r_state == ST_MEM);
    assign dmem_we    = dmem_req && data_w;
    assign alu_en     = !rst && (r_state == ST_EXECUTE);
    assign reg_we     = !rst && (r_state == ST_WB);
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign trap       = r_trap;
    assign trap_cause = r_cause;
    assign state      = r_state;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed-vector bench for core_sequencer (RESET_PC=0, BUS_TIMEOUT=16).
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack, ir_load, instr_legal;
    logic        jump, jalr, branch, branch_taken, data_r, data_w, reg_w;
    logic [31:0] imm, alu_result, pc, pc_plus4;
    logic        dmem_req, dmem_we, dmem_ack, reg_we, alu_en, trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    core_sequencer #(.RESET_PC(32'h0), .BUS_TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
        .instr_legal(instr_legal), .jump(jump), .jalr(jalr), .branch(branch),
        .branch_taken(branch_taken), .data_r(data_r), .data_w(data_w), .reg_w(reg_w),
        .imm(imm), .alu_result(alu_result),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_we(reg_we), .alu_en(alu_en), .pc(pc), .pc_plus4(pc_plus4),
        .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        instr_legal = 1'b1; jump = 1'b0; jalr = 1'b0; branch = 1'b0;
        branch_taken = 1'b0; data_r = 1'b0; data_w = 1'b0; reg_w = 1'b0;
        imm = 32'h0; alu_result = 32'h0; imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // From FETCH: wait n cycles, then ack; ends in DECODE.
    task automatic do_fetch(input int n);
        repeat (n) tick();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
    endtask

    // One non-memory instruction from FETCH back to FETCH; ALU inputs are only valid in EXECUTE.
    task automatic run_op(input logic j, input logic jr, input logic br, input logic tk,
                          input logic rw, input logic [31:0] imm_v, input logic [31:0] alu_v);
        jump = j; jalr = jr; branch = br; reg_w = rw; imm = imm_v;
        do_fetch(0);
        tick();
        branch_taken = tk; alu_result = alu_v;
        tick();
        branch_taken = ~tk; alu_result = 32'hDEAD_BEEF;
        if (rw) tick();
        clear_in();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_in();
        imem_ack = 1'b1;
        tick();
        nvec++; if ({imem_req, ir_load, dmem_req, dmem_we, reg_we, alu_en} !== 6'b0) begin
            nerr++; $display("FAIL reset_strobes got %b exp 000000", {imem_req, ir_load, dmem_req, dmem_we, reg_we, alu_en});
        end
        nvec++; if (state !== 3'd0 || pc !== 32'h0 || trap !== 1'b0 || trap_cause !== 2'd0) begin
            nerr++; $display("FAIL reset_regs got state=%0d pc=%h trap=%b cause=%0d exp 0/0/0/0", state, pc, trap, trap_cause);
        end
        imem_ack = 1'b0;
        rst = 1'b0;
        #1;
        nvec++; if (imem_req !== 1'b1 || pc_plus4 !== 32'h4) begin
            nerr++; $display("FAIL reset_release got req=%b pc4=%h exp 1 00000004", imem_req, pc_plus4);
        end
    endtask

    task automatic test_addi();
        reg_w = 1'b1;
        for (int c = 0; c < 3; c++) begin
            imem_ack = (c == 2);
            #1;
            nvec++; if (state !== 3'd0 || imem_req !== 1'b1 || ir_load !== 1'(c == 2)) begin
                nerr++; $display("FAIL addi_fetch c=%0d got state=%0d req=%b ld=%b exp 0 1 %b", c, state, imem_req, ir_load, c == 2);
            end
            tick();
        end
        imem_ack = 1'b0;
        nvec++; if (state !== 3'd1 || imem_req !== 1'b0 || ir_load !== 1'b0) begin
            nerr++; $display("FAIL addi_decode got state=%0d req=%b ld=%b exp 1 0 0", state, imem_req, ir_load);
        end
        tick();
        nvec++; if (state !== 3'd2 || alu_en !== 1'b1) begin
            nerr++; $display("FAIL addi_exec got state=%0d alu_en=%b exp 2 1", state, alu_en);
        end
        tick();
        nvec++; if (state !== 3'd4 || reg_we !== 1'b1 || alu_en !== 1'b0 || pc !== 32'h0) begin
            nerr++; $display("FAIL addi_wb got state=%0d we=%b alu_en=%b pc=%h exp 4 1 0 00000000", state, reg_we, alu_en, pc);
        end
        tick();
        nvec++; if (state !== 3'd0 || reg_we !== 1'b0 || pc !== 32'h4) begin
            nerr++; $display("FAIL addi_done got state=%0d we=%b pc=%h exp 0 0 00000004", state, reg_we, pc);
        end
        clear_in();
    endtask

    task automatic test_load_store();
        data_r = 1'b1; reg_w = 1'b1;
        do_fetch(1);
        tick();
        dmem_ack = 1'b1;
        #1;
        nvec++; if (state !== 3'd2 || dmem_req !== 1'b0) begin
            nerr++; $display("FAIL load_exec got state=%0d dreq=%b exp 2 0", state, dmem_req);
        end
        tick();
        dmem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            dmem_ack = (c == 2);
            #1;
            nvec++; if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b0 || imem_req !== 1'b0) begin
                nerr++; $display("FAIL load_mem c=%0d got state=%0d dreq=%b dwe=%b ireq=%b exp 3 1 0 0", c, state, dmem_req, dmem_we, imem_req);
            end
            tick();
        end
        dmem_ack = 1'b0;
        nvec++; if (state !== 3'd4 || reg_we !== 1'b1 || dmem_req !== 1'b0) begin
            nerr++; $display("FAIL load_wb got state=%0d we=%b dreq=%b exp 4 1 0", state, reg_we, dmem_req);
        end
        tick();
        nvec++; if (state !== 3'd0 || pc !== 32'h8) begin
            nerr++; $display("FAIL load_pc got state=%0d pc=%h exp 0 00000008", state, pc);
        end
        clear_in();
        data_w = 1'b1;
        do_fetch(0);
        tick();
        tick();
        dmem_ack = 1'b1;
        #1;
        nvec++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
            nerr++; $display("FAIL store_mem got dreq=%b dwe=%b exp 1 1", dmem_req, dmem_we);
        end
        tick();
        dmem_ack = 1'b0;
        nvec++; if (state !== 3'd0 || reg_we !== 1'b0 || pc !== 32'hC) begin
            nerr++; $display("FAIL store_done got state=%0d we=%b pc=%h exp 0 0 0000000c", state, reg_we, pc);
        end
        clear_in();
    endtask

    task automatic test_branches();
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00F4, 32'h0);
        nvec++; if (pc !== 32'h100) begin
            nerr++; $display("FAIL jal_pc got %h exp 00000100", pc);
        end
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
        nvec++; if (pc !== 32'hF8) begin
            nerr++; $display("FAIL br_taken_pc got %h exp 000000f8", pc);
        end
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h0);
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
        nvec++; if (pc !== 32'h104 || pc_plus4 !== 32'h108) begin
            nerr++; $display("FAIL br_not_taken_pc got %h/%h exp 00000104/00000108", pc, pc_plus4);
        end
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0203);
        nvec++; if (pc !== 32'h202) begin
            nerr++; $display("FAIL jalr_pc got %h exp 00000202", pc);
        end
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FDFA, 32'h0);
        nvec++; if (pc !== 32'hFFFF_FFFC) begin
            nerr++; $display("FAIL jal_top_pc got %h exp fffffffc", pc);
        end
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        nvec++; if (pc !== 32'h0) begin
            nerr++; $display("FAIL pc_wrap got %h exp 00000000", pc);
        end
    endtask

    task automatic test_ack_at_limit();
        repeat (15) tick();
        imem_ack = 1'b1;
        #1;
        nvec++; if (imem_req !== 1'b1 || state !== 3'd0) begin
            nerr++; $display("FAIL limit_req16 got req=%b state=%0d exp 1 0", imem_req, state);
        end
        tick();
        imem_ack = 1'b0;
        nvec++; if (state !== 3'd1 || trap !== 1'b0) begin
            nerr++; $display("FAIL limit_ack got state=%0d trap=%b exp 1 0", state, trap);
        end
        tick();
        tick();
        nvec++; if (state !== 3'd0 || pc !== 32'h4) begin
            nerr++; $display("FAIL limit_done got state=%0d pc=%h exp 0 00000004", state, pc);
        end
    endtask

    task automatic test_imem_timeout();
        int n;
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        nvec++; if (n !== 16) begin
            nerr++; $display("FAIL imem_to_cycles got %0d exp 16", n);
        end
        nvec++; if (trap !== 1'b1 || trap_cause !== 2'd2 || state !== 3'd7 || pc !== 32'h4) begin
            nerr++; $display("FAIL imem_to_trap got trap=%b cause=%0d state=%0d pc=%h exp 1 2 7 00000004", trap, trap_cause, state, pc);
        end
        imem_ack = 1'b1;
        repeat (3) tick();
        nvec++; if (state !== 3'd7 || imem_req !== 1'b0 || ir_load !== 1'b0 || trap_cause !== 2'd2 || pc !== 32'h4) begin
            nerr++; $display("FAIL trap_hold got state=%0d req=%b ld=%b cause=%0d pc=%h exp 7 0 0 2 00000004", state, imem_req, ir_load, trap_cause, pc);
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        instr_legal = 1'b0;
        do_fetch(0);
        tick();
        nvec++; if (state !== 3'd7 || trap !== 1'b1 || trap_cause !== 2'd1 || pc !== 32'h4 || alu_en !== 1'b0) begin
            nerr++; $display("FAIL illegal got state=%0d trap=%b cause=%0d pc=%h alu_en=%b exp 7 1 1 00000004 0", state, trap, trap_cause, pc, alu_en);
        end
        clear_in();
    endtask

    task automatic test_dmem_timeout();
        int n;
        do_reset();
        data_w = 1'b1;
        do_fetch(0);
        tick();
        tick();
        n = 0;
        while (dmem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        nvec++; if (n !== 16 || trap_cause !== 2'd3 || state !== 3'd7 || pc !== 32'h0 || dmem_we !== 1'b0) begin
            nerr++; $display("FAIL dmem_to got n=%0d cause=%0d state=%0d pc=%h we=%b exp 16 3 7 00000000 0", n, trap_cause, state, pc, dmem_we);
        end
        clear_in();
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        data_r = 1'b1; reg_w = 1'b1;
        do_fetch(0);
        tick();
        tick();
        nvec++; if (dmem_req !== 1'b1 || pc !== 32'h4) begin
            nerr++; $display("FAIL mid_mem_pre got dreq=%b pc=%h exp 1 00000004", dmem_req, pc);
        end
        #1 rst = 1'b1;
        #1;
        nvec++; if (dmem_req !== 1'b0 || imem_req !== 1'b0 || state !== 3'd0 || pc !== 32'h0) begin
            nerr++; $display("FAIL mid_mem_rst got dreq=%b ireq=%b state=%0d pc=%h exp 0 0 0 00000000", dmem_req, imem_req, state, pc);
        end
        tick();
        rst = 1'b0;
        clear_in();
        #1;
        nvec++; if (imem_req !== 1'b1 || state !== 3'd0) begin
            nerr++; $display("FAIL mid_mem_release got req=%b state=%0d exp 1 0", imem_req, state);
        end
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        nvec++; if (pc !== 32'h4 || trap !== 1'b0) begin
            nerr++; $display("FAIL mid_mem_resume got pc=%h trap=%b exp 00000004 0", pc, trap);
        end
    endtask

    initial begin
        clear_in();
        test_reset();
        test_addi();
        test_load_store();
        test_branches();
        test_ack_at_limit();
        test_imem_timeout();
        test_illegal();
        test_dmem_timeout();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
